// File: rtl/gfx_pixel_arbiter.sv
// Frame-granular round-robin arbiter merging two pixel streams into one
// registered valid/ready output stage that feeds the framebuffer writer.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   s0_x/y/color         source 0 pixel coordinates and colour
//   s0_valid/last        source 0 beat valid; final beat of its frame
//   s0_ready             source 0 beat accepted when s0_valid & s0_ready
//   s1_*                 same set for source 1
//   m_x/y/color          registered output pixel
//   m_valid/last         output beat valid; final beat of granted frame
//   m_ready              downstream accepts when m_valid & m_ready
//   grant                one-hot current owner, 2'b00 while idle
module gfx_pixel_arbiter #(
  parameter int VGA_WIDTH  = 640,
  parameter int VGA_HEIGHT = 480,
  parameter int COLOR_BITS = 12,
  localparam int FB_X_BITS = $clog2(VGA_WIDTH),
  localparam int FB_Y_BITS = $clog2(VGA_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FB_X_BITS-1:0]  s0_x,
  input  logic [FB_Y_BITS-1:0]  s0_y,
  input  logic [COLOR_BITS-1:0] s0_color,
  input  logic                  s0_valid,
  input  logic                  s0_last,
  output logic                  s0_ready,
  input  logic [FB_X_BITS-1:0]  s1_x,
  input  logic [FB_Y_BITS-1:0]  s1_y,
  input  logic [COLOR_BITS-1:0] s1_color,
  input  logic                  s1_valid,
  input  logic                  s1_last,
  output logic                  s1_ready,
  output logic [FB_X_BITS-1:0]  m_x,
  output logic [FB_Y_BITS-1:0]  m_y,
  output logic [COLOR_BITS-1:0] m_color,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  // 0: source 0 wins a tie, 1: source 1 wins a tie
  logic                  ptr_q, ptr_d;
  logic [FB_X_BITS-1:0]  m_x_q, m_x_d;
  logic [FB_Y_BITS-1:0]  m_y_q, m_y_d;
  logic [COLOR_BITS-1:0] m_color_q, m_color_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;

  logic                  slot_free;
  logic                  acc;
  logic [FB_X_BITS-1:0]  sel_x;
  logic [FB_Y_BITS-1:0]  sel_y;
  logic [COLOR_BITS-1:0] sel_color;
  logic                  sel_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      m_x_q     <= '0;
      m_y_q     <= '0;
      m_color_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      m_x_q     <= m_x_d;
      m_y_q     <= m_y_d;
      m_color_q <= m_color_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    m_x_d     = m_x_q;
    m_y_d     = m_y_q;
    m_color_d = m_color_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    acc       = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    sel_last  = 1'b0;
    // Output slot can take a beat if empty or being drained this cycle
    slot_free = !m_valid_q || m_ready;

    unique case (state_q)
      IDLE: begin
        if (s0_valid && (!s1_valid || !ptr_q)) begin
          state_d = GRANT0;
        end else if (s1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        s0_ready  = slot_free;
        acc       = s0_valid && slot_free;
        sel_x     = s0_x;
        sel_y     = s0_y;
        sel_color = s0_color;
        sel_last  = s0_last;
      end
      GRANT1: begin
        s1_ready  = slot_free;
        acc       = s1_valid && slot_free;
        sel_x     = s1_x;
        sel_y     = s1_y;
        sel_color = s1_color;
        sel_last  = s1_last;
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      m_x_d     = sel_x;
      m_y_d     = sel_y;
      m_color_d = sel_color;
      m_valid_d = 1'b1;
      m_last_d  = sel_last;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    // End of frame: release ownership and hand priority to the other side
    if (acc && sel_last) begin
      state_d = IDLE;
      ptr_d   = (state_q == GRANT0);
    end
  end

  assign m_x     = m_x_q;
  assign m_y     = m_y_q;
  assign m_color = m_color_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign grant   = {state_q == GRANT1, state_q == GRANT0};

endmodule

// File: tb/tb_gfx_pixel_arbiter.sv
// Scoreboard bench for gfx_pixel_arbiter: source queues feed beats,
// expected output order is queued at load time and checked on handshake.
module tb_gfx_pixel_arbiter;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] c;
    logic        l;
  } beat_t;

  logic        clk;
  logic        reset;
  logic [9:0]  s0_x, s1_x, m_x;
  logic [8:0]  s0_y, s1_y, m_y;
  logic [11:0] s0_color, s1_color, m_color;
  logic        s0_valid, s0_last, s0_ready;
  logic        s1_valid, s1_last, s1_ready;
  logic        m_valid, m_last, m_ready;
  logic [1:0]  grant;

  gfx_pixel_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .s0_x     (s0_x),
    .s0_y     (s0_y),
    .s0_color (s0_color),
    .s0_valid (s0_valid),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_x     (s1_x),
    .s1_y     (s1_y),
    .s1_color (s1_color),
    .s1_valid (s1_valid),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .m_x      (m_x),
    .m_y      (m_y),
    .m_color  (m_color),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp;
  int    n_bad;
  beat_t q0[$];
  beat_t q1[$];
  beat_t sb[$];
  logic  rst_v;
  logic  mr;
  logic  r0_seen;
  logic  r1_seen;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic frame(int src, int n, int base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.x = 10'(base + i);
      b.y = 9'(src);
      b.c = 12'(src * 256 + base + i);
      b.l = (i == n - 1);
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
      sb.push_back(b);
    end
  endtask

  task automatic step();
    logic  a0;
    logic  a1;
    beat_t e;
    @(negedge clk);
    reset   = rst_v;
    m_ready = mr;
    s0_valid = (q0.size() > 0);
    s1_valid = (q1.size() > 0);
    if (q0.size() > 0) {s0_x, s0_y, s0_color, s0_last} = q0[0];
    else {s0_x, s0_y, s0_color, s0_last} = '0;
    if (q1.size() > 0) {s1_x, s1_y, s1_color, s1_last} = q1[0];
    else {s1_x, s1_y, s1_color, s1_last} = '0;
    #1;
    r0_seen = s0_ready;
    r1_seen = s1_ready;
    a0 = !rst_v && s0_valid && s0_ready;
    a1 = !rst_v && s1_valid && s1_ready;
    if (!rst_v && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("beat", {m_x, m_y, m_color, m_last}, e);
      end
    end
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !m_valid)
        break;
      step();
    end
    chk("drain_src", 32'(q0.size() + q1.size()), 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    step();
    step();
    rst_v = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
  endtask

  int    exp_g[12];
  logic [9:0] hx;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    rst_v = 1'b1;
    mr = 1'b1;
    m_ready = 1'b1;
    {s0_x, s0_y, s0_color, s0_valid, s0_last} = '0;
    {s1_x, s1_y, s1_color, s1_valid, s1_last} = '0;
    do_reset();

    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mlast", 32'(m_last), 32'd0);
    chk("rst_mdata", {m_x, m_y, m_color, 1'b0}, 32'd0);
    chk("rst_rdy", {30'd0, s0_ready, s1_ready}, 32'd0);

    // single source 4-beat frame, latency and m_last placement
    frame(0, 4, 0);
    step();
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_mv0", 32'(m_valid), 32'd0);
    step();
    chk("t1_mv1", 32'(m_valid), 32'd1);
    chk("t1_x0", 32'(m_x), 32'd0);
    step();
    step();
    chk("t1_x2", 32'(m_x), 32'd2);
    chk("t1_nolast", 32'(m_last), 32'd0);
    step();
    chk("t1_x3", 32'(m_x), 32'd3);
    chk("t1_last", 32'(m_last), 32'd1);
    chk("t1_gidle", 32'(grant), 32'd0);
    drain();

    // both sources contending from reset: strict alternation
    do_reset();
    exp_g = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
    frame(0, 2, 10);
    frame(1, 2, 20);
    frame(0, 2, 30);
    frame(1, 2, 40);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t2_g%0d", i), 32'(grant), 32'(exp_g[i]));
    end
    drain();

    // downstream stall mid-frame
    frame(0, 8, 0);
    for (int i = 0; i < 4; i++) step();
    hx = m_x;
    chk("t3_pre", 32'(m_valid), 32'd1);
    mr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_rdy", 32'(r0_seen), 32'd0);
      chk("t3_hold", {21'd0, m_valid, m_x}, {21'd0, 1'b1, hx});
    end
    mr = 1'b1;
    drain();

    // s1 waits through an s0 frame without preempting
    do_reset();
    frame(0, 3, 50);
    step();
    chk("t4_g0", 32'(grant), 32'd1);
    frame(1, 2, 60);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_s1rdy", 32'(r1_seen), 32'd0);
    end
    chk("t4_idle", 32'(grant), 32'd0);
    step();
    chk("t4_g1", 32'(grant), 32'd2);
    drain();

    // reset mid-frame of s1, then s0 favoured again; single-beat frames
    frame(1, 4, 70);
    step();
    chk("t5_g1", 32'(grant), 32'd2);
    step();
    step();
    rst_v = 1'b1;
    step();
    chk("t5_rmv", 32'(m_valid), 32'd0);
    chk("t5_rg", 32'(grant), 32'd0);
    rst_v = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
    frame(0, 1, 90);
    frame(1, 1, 95);
    step();
    chk("t5_s0first", 32'(grant), 32'd1);
    step();
    chk("t6_mv", 32'(m_valid), 32'd1);
    chk("t6_ml", 32'(m_last), 32'd1);
    chk("t6_gi", 32'(grant), 32'd0);
    step();
    chk("t6_mv0", 32'(m_valid), 32'd0);
    chk("t6_g1", 32'(grant), 32'd2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
